mat_slot_allocator: RTL and testbench
=====================================

// Module: mat_slot_allocator
// PURPOSE
// - Storage-slot scheduler for the matrix store. Arbitrates slot allocation requests from INPUT, GEN and CALC (result write-back).
// - Keeps a per-size (rows x cols) ring pointer and occupancy count, and returns the physical slot ID each writer must use.
// - Enforces the runtime per-size limit from SETTINGS and answers occupancy queries for DISPLAY/CALC menus.
// PARAMETERS
// - NUM_REQ    3                    requesters; index 0=INPUT, 1=GEN, 2=CALC
// - MAX_R      MAX_ROWS (10)        max legal rows
// - MAX_C      MAX_COLS (12)        max legal cols
// - PHYS       PHYSICAL_MAX_PER_DIM (2)  physical slots per size
// PORTS
// - clk               in   1                  system clock (100 MHz)
// - rst_n             in   1                  reset, asynchronous, active-low
// - req_i             in   NUM_REQ            level request; held until own gnt_o bit seen
// - req_rows_i        in   NUM_REQ*ROW_IDX_W  requested rows, packed per requester
// - req_cols_i        in   NUM_REQ*COL_IDX_W  requested cols, packed per requester
// - limit_i           in   PTR_W              logical per-size limit; clamped to 1..PHYS
// - clear_i           in   1                  sync pulse: drop all allocations
// - query_rows_i      in   ROW_IDX_W          occupancy query rows
// - query_cols_i      in   COL_IDX_W          occupancy query cols
// - gnt_o             out  NUM_REQ            one-hot, 1-cycle grant pulse
// - gnt_slot_o        out  MAT_ID_W           slot ID, valid with gnt_o
// - gnt_err_o         out  1                  illegal dims, valid with gnt_o
// - gnt_overwrite_o   out  1                  granted slot replaces the oldest matrix
// - query_cnt_o       out  PTR_W              min(cnt, eff_limit); registered, 1-cycle latency
// - busy_o            out  1                  high in CHECK and GRANT
// BEHAVIOUR
// - Reset: all outputs 0; every wr_ptr/cnt 0; rr_last = NUM_REQ-1, so requester 0 wins first.
// - FSM IDLE -> CHECK -> GRANT -> IDLE.
//   - IDLE: if |req_i, round-robin pick from (rr_last+1) mod NUM_REQ; latch idx, rows, cols.
//   - CHECK: legal iff 1<=rows<=MAX_R and 1<=cols<=MAX_C.
//     size_idx = (rows-1)*MAX_C + (cols-1); eff_limit = clamp(limit_i, 1, PHYS).
//     ptr = (wr_ptr[size_idx] >= eff_limit) ? 0 : wr_ptr[size_idx].
//   - GRANT: gnt_o[idx] = 1 for exactly one cycle; rr_last = idx.
//     - Legal: gnt_slot_o = size_idx*PHYS + ptr; gnt_overwrite_o = (cnt >= eff_limit);
//       wr_ptr = (ptr+1 == eff_limit) ? 0 : ptr+1; cnt = min(cnt+1, eff_limit).
//     - Illegal: gnt_err_o = 1, gnt_slot_o = 0, no table update.
// - Latency: req seen in IDLE at cycle N -> gnt_o at N+2. Max throughput is 1 grant per 3 cycles.
// - Handshake: a requester must drop req_i the cycle after its gnt_o. req_i/dims must be stable from assertion until grant.
// - Outside GRANT, gnt_slot_o, gnt_err_o and gnt_overwrite_o hold 0.
// - Limit lowered below cnt: no table rewrite; query and overwrite compare against eff_limit; a pointer at or above the limit wraps to 0 on the next grant.
// - clear_i has priority over everything: next cycle all wr_ptr/cnt = 0 and FSM -> IDLE. An in-flight CHECK/GRANT is aborted with no gnt_o; the requester keeps req_i and is re-arbitrated. rr_last is unchanged.
// - Query: query_cnt_o is registered from the query inputs; illegal query dims -> 0.
// - Async reset mid-transaction: outputs drop to 0 immediately; the table resets.
// STRUCTURE
// - Add to project_pkg:
//   - NUM_REQ
//   - typedef enum {REQ_INPUT, REQ_GEN, REQ_CALC} req_id_t
//   - typedef logic [MAT_ID_W-1:0] mat_id_t
//   - function size_idx(rows, cols)
// - Sub-module rr_arbiter: combinational NUM_REQ-way round-robin picker (req, rr_last -> one-hot + idx).
// - Table: two flop arrays, wr_ptr[MAT_SIZE_CNT] and cnt[MAT_SIZE_CNT], each PTR_W wide.
// TESTING
// - T1 limit=2; req0 rows=2 cols=3 at cycle N -> gnt_o=001 at N+2, slot=28, err=0, ovw=0. Query(2,3) -> 1.
// - T2 same size granted 3 times -> slots 28, 29, 28; third has ovw=1; query stays 2.
// - T3 req_i=111 at once, dims (1,1), (1,2), (1,3) -> grants 001/slot0, 010/slot2, 100/slot4, each 3 cycles apart. Re-request all -> order 0, 1, 2 again.
// - T4 rows=0 or cols=13 -> gnt with err=1, slot=0; all queries unchanged.
// - T5 limit=2, one grant (2,3) -> slot 28; set limit=1 -> next slot 28, ovw=1, query=1. limit_i=0 behaves as 1; limit_i=7 behaves as 2.
// - T6 clear_i in CHECK cycle -> no gnt that round; regranted later with slot 28, ovw=0. rst_n low during GRANT -> gnt_o=0 in the same cycle.

Source files
------------

// File: rtl/mat_slot_allocator_pkg.sv
// mat_slot_allocator_pkg: shared sizes, types and helpers for the matrix slot allocator.
package mat_slot_allocator_pkg;
   localparam int MAX_ROWS             = 10;
   localparam int MAX_COLS             = 12;
   localparam int PHYSICAL_MAX_PER_DIM = 2;
   localparam int NUM_REQ              = 3;
   localparam int ROW_IDX_W            = 4;
   localparam int COL_IDX_W            = 4;
   localparam int PTR_W                = 3;
   localparam int MAT_SIZE_CNT         = MAX_ROWS * MAX_COLS;
   localparam int SIZE_IDX_W           = $clog2(MAT_SIZE_CNT);
   localparam int MAT_ID_W             = $clog2(MAT_SIZE_CNT * PHYSICAL_MAX_PER_DIM);
   localparam int REQ_IDX_W            = $clog2(NUM_REQ);

   typedef enum logic [REQ_IDX_W-1:0] {REQ_INPUT, REQ_GEN, REQ_CALC} req_id_t;
   typedef logic [MAT_ID_W-1:0] mat_id_t;

   function automatic logic dims_ok(input logic [ROW_IDX_W-1:0] rows, input logic [COL_IDX_W-1:0] cols);
      return (rows != '0) && (int'(rows) <= MAX_ROWS) && (cols != '0) && (int'(cols) <= MAX_COLS);
   endfunction

   function automatic logic [SIZE_IDX_W-1:0] size_idx(input logic [ROW_IDX_W-1:0] rows, input logic [COL_IDX_W-1:0] cols);
      return SIZE_IDX_W'((int'(rows) - 1) * MAX_COLS + int'(cols) - 1);
   endfunction

   function automatic logic [PTR_W-1:0] eff_limit(input logic [PTR_W-1:0] lim);
      return (lim == '0) ? PTR_W'(1) : (int'(lim) > PHYSICAL_MAX_PER_DIM) ? PTR_W'(PHYSICAL_MAX_PER_DIM) : lim;
   endfunction

   function automatic mat_id_t slot_id(input logic [SIZE_IDX_W-1:0] s, input logic [PTR_W-1:0] p);
      return MAT_ID_W'(int'(s) * PHYSICAL_MAX_PER_DIM + int'(p));
   endfunction

   function automatic logic [PTR_W-1:0] sat_cnt(input logic [PTR_W-1:0] c, input logic [PTR_W-1:0] lim);
      return (c > lim) ? lim : c;
   endfunction

   function automatic req_id_t rr_next(input req_id_t last, input int k);
      return req_id_t'((int'(last) + k) % NUM_REQ);
   endfunction
endpackage

// File: rtl/mat_slot_allocator_rr_arbiter.sv
// mat_slot_allocator_rr_arbiter: combinational round-robin pick starting after the last winner.
module mat_slot_allocator_rr_arbiter
   import mat_slot_allocator_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  req_id_t            last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output req_id_t            idx_o
);
   req_id_t cand;
   logic    found;

   always_comb begin
      gnt_o = '0;
      idx_o = REQ_INPUT;
      cand  = REQ_INPUT;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = rr_next(last_i, k);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end
endmodule

// File: rtl/mat_slot_allocator.sv
// mat_slot_allocator: arbitrates slot requests and hands out ring-allocated physical slot IDs per matrix size.
module mat_slot_allocator
   import mat_slot_allocator_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ*ROW_IDX_W-1:0] req_rows_i,
   input  logic [NUM_REQ*COL_IDX_W-1:0] req_cols_i,
   input  logic [PTR_W-1:0]             limit_i,
   input  logic                         clear_i,
   input  logic [ROW_IDX_W-1:0]         query_rows_i,
   input  logic [COL_IDX_W-1:0]         query_cols_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic [MAT_ID_W-1:0]          gnt_slot_o,
   output logic                         gnt_err_o,
   output logic                         gnt_overwrite_o,
   output logic [PTR_W-1:0]             query_cnt_o,
   output logic                         busy_o
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_GRANT = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [NUM_REQ-1:0]    oh_q, arb_oh;
   req_id_t               idx_q, rr_last_q, arb_idx;
   logic [ROW_IDX_W-1:0]  rows_q;
   logic [COL_IDX_W-1:0]  cols_q;
   logic                  legal_q, ovw_q;
   logic [SIZE_IDX_W-1:0] size_q;
   logic [PTR_W-1:0]      nxt_q, eff_q, query_q;
   mat_id_t               slot_q;
   logic [PTR_W-1:0]      wr_ptr_q [MAT_SIZE_CNT];
   logic [PTR_W-1:0]      cnt_q    [MAT_SIZE_CNT];

   logic                  chk_legal, q_legal, fire;
   logic [SIZE_IDX_W-1:0] chk_size, q_size;
   logic [PTR_W-1:0]      chk_eff, chk_ptr, chk_nxt;

   mat_slot_allocator_rr_arbiter u_arb (
      .req_i  (req_i),
      .last_i (rr_last_q),
      .gnt_o  (arb_oh),
      .idx_o  (arb_idx)
   );

   // clear_i kills a grant in its own cycle, so outputs are gated combinationally
   assign fire            = (state_q == ST_GRANT) && !clear_i;
   assign gnt_o           = fire ? oh_q : '0;
   assign gnt_slot_o      = (fire && legal_q) ? slot_q : '0;
   assign gnt_err_o       = fire && !legal_q;
   assign gnt_overwrite_o = fire && legal_q && ovw_q;
   assign busy_o          = (state_q == ST_CHECK) || (state_q == ST_GRANT);
   assign query_cnt_o     = query_q;

   always_comb begin
      chk_legal = dims_ok(rows_q, cols_q);
      chk_size  = chk_legal ? size_idx(rows_q, cols_q) : '0;
      chk_eff   = eff_limit(limit_i);
      chk_ptr   = (wr_ptr_q[chk_size] >= chk_eff) ? '0 : wr_ptr_q[chk_size];
      chk_nxt   = (chk_ptr + PTR_W'(1) == chk_eff) ? '0 : chk_ptr + PTR_W'(1);
      q_legal   = dims_ok(query_rows_i, query_cols_i);
      q_size    = q_legal ? size_idx(query_rows_i, query_cols_i) : '0;
      state_d   = clear_i ? ST_IDLE :
                  (state_q == ST_IDLE)  ? ((|req_i) ? ST_CHECK : ST_IDLE) :
                  (state_q == ST_CHECK) ? ST_GRANT : ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         oh_q      <= '0;
         idx_q     <= REQ_INPUT;
         rr_last_q <= REQ_CALC;
         rows_q    <= '0;
         cols_q    <= '0;
         legal_q   <= 1'b0;
         ovw_q     <= 1'b0;
         size_q    <= '0;
         nxt_q     <= '0;
         eff_q     <= '0;
         slot_q    <= '0;
         query_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && |req_i) begin
            oh_q   <= arb_oh;
            idx_q  <= arb_idx;
            rows_q <= req_rows_i[arb_idx*ROW_IDX_W +: ROW_IDX_W];
            cols_q <= req_cols_i[arb_idx*COL_IDX_W +: COL_IDX_W];
         end
         if (state_q == ST_CHECK) begin
            legal_q <= chk_legal;
            size_q  <= chk_size;
            eff_q   <= chk_eff;
            nxt_q   <= chk_nxt;
            ovw_q   <= cnt_q[chk_size] >= chk_eff;
            slot_q  <= chk_legal ? slot_id(chk_size, chk_ptr) : '0;
         end
         if (fire) rr_last_q <= idx_q;
         query_q <= q_legal ? sat_cnt(cnt_q[q_size], eff_limit(limit_i)) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MAT_SIZE_CNT; k++) begin
            wr_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
      end else if (clear_i) begin
         for (int k = 0; k < MAT_SIZE_CNT; k++) begin
            wr_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
      end else if (fire && legal_q) begin
         wr_ptr_q[size_q] <= nxt_q;
         cnt_q[size_q]    <= sat_cnt(cnt_q[size_q] + PTR_W'(1), eff_q);
      end
   end
endmodule

// File: tb/tb_mat_slot_allocator.sv
// tb_mat_slot_allocator: table-driven vectors plus directed sequences for arbitration, clear and reset.
module tb_mat_slot_allocator;
   logic        clk, rst_n, clear_i;
   logic [2:0]  req_i, gnt_o, limit_i, query_cnt_o;
   logic [11:0] req_rows_i, req_cols_i;
   logic [3:0]  query_rows_i, query_cols_i;
   logic [7:0]  gnt_slot_o;
   logic        gnt_err_o, gnt_overwrite_o, busy_o;
   int          n_tests = 0, n_fail = 0;

   typedef struct {
      int         r;
      logic [3:0] rows, cols;
      logic [2:0] lim;
      logic [3:0] qr, qc;
      logic [2:0] gnt;
      logic [7:0] slot;
      logic       err, ovw;
      logic [2:0] q;
   } vec_t;

   mat_slot_allocator dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_rows_i(req_rows_i), .req_cols_i(req_cols_i),
      .limit_i(limit_i), .clear_i(clear_i), .query_rows_i(query_rows_i), .query_cols_i(query_cols_i),
      .gnt_o(gnt_o), .gnt_slot_o(gnt_slot_o), .gnt_err_o(gnt_err_o), .gnt_overwrite_o(gnt_overwrite_o),
      .query_cnt_o(query_cnt_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic vec_t mk(int r, logic [3:0] rows, logic [3:0] cols, logic [2:0] lim, logic [3:0] qr,
                               logic [3:0] qc, logic [2:0] gnt, logic [7:0] slot, logic err, logic ovw, logic [2:0] q);
      vec_t v;
      v.r = r; v.rows = rows; v.cols = cols; v.lim = lim; v.qr = qr; v.qc = qc;
      v.gnt = gnt; v.slot = slot; v.err = err; v.ovw = ovw; v.q = q;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [3:0] rows, input logic [3:0] cols);
      req_rows_i[r*4 +: 4] = rows;
      req_cols_i[r*4 +: 4] = cols;
   endtask

   task automatic wait_gnt(output int lat);
      lat = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         lat++;
         if (|gnt_o) break;
      end
   endtask

   task automatic expect_gnt(input string name, input int lat_exp, input logic [2:0] g,
                             input logic [7:0] slot, input logic err, input logic ovw);
      int lat;
      wait_gnt(lat);
      check({name, " latency"}, lat, lat_exp);
      check({name, " gnt"}, gnt_o, g);
      check({name, " slot"}, gnt_slot_o, slot);
      check({name, " err"}, gnt_err_o, err);
      check({name, " ovw"}, gnt_overwrite_o, ovw);
   endtask

   vec_t vecs [12];

   initial begin
      vecs[0]  = mk(0, 2, 3,  2, 2, 3,  3'b001, 28,  0, 0, 1);
      vecs[1]  = mk(1, 2, 3,  2, 2, 3,  3'b010, 29,  0, 0, 2);
      vecs[2]  = mk(2, 2, 3,  2, 2, 3,  3'b100, 28,  0, 1, 2);
      vecs[3]  = mk(0, 0, 3,  2, 2, 3,  3'b001, 0,   1, 0, 2);
      vecs[4]  = mk(1, 1, 13, 2, 2, 3,  3'b010, 0,   1, 0, 2);
      vecs[5]  = mk(2, 10, 12, 2, 10, 12, 3'b100, 238, 0, 0, 1);
      vecs[6]  = mk(0, 3, 4,  2, 3, 4,  3'b001, 54,  0, 0, 1);
      vecs[7]  = mk(1, 3, 4,  1, 3, 4,  3'b010, 54,  0, 1, 1);
      vecs[8]  = mk(2, 2, 3,  0, 2, 3,  3'b100, 28,  0, 1, 1);
      vecs[9]  = mk(0, 2, 3,  7, 2, 3,  3'b001, 28,  0, 0, 2);
      vecs[10] = mk(1, 2, 3,  7, 2, 3,  3'b010, 29,  0, 1, 2);
      vecs[11] = mk(2, 1, 1,  2, 1, 1,  3'b100, 0,   0, 0, 1);

      rst_n = 1'b0; clear_i = 1'b0; req_i = '0; req_rows_i = '0; req_cols_i = '0;
      limit_i = 3'd2; query_rows_i = 4'd2; query_cols_i = 4'd3;
      repeat (3) @(negedge clk);
      check("reset gnt", gnt_o, 0);
      check("reset busy", busy_o, 0);
      check("reset query", query_cnt_o, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset slot", gnt_slot_o, 0);

      for (int i = 0; i < 12; i++) begin
         limit_i = vecs[i].lim;
         query_rows_i = vecs[i].qr;
         query_cols_i = vecs[i].qc;
         set_req(vecs[i].r, vecs[i].rows, vecs[i].cols);
         req_i[vecs[i].r] = 1'b1;
         expect_gnt($sformatf("v%0d", i), 2, vecs[i].gnt, vecs[i].slot, vecs[i].err, vecs[i].ovw);
         req_i[vecs[i].r] = 1'b0;
         repeat (2) @(negedge clk);
         check($sformatf("v%0d query", i), query_cnt_o, vecs[i].q);
      end

      // limit lowered below the stored count: query saturates at the new limit
      query_rows_i = 4'd2; query_cols_i = 4'd3; limit_i = 3'd1;
      repeat (2) @(negedge clk);
      check("low limit query", query_cnt_o, 1);
      limit_i = 3'd2;
      repeat (2) @(negedge clk);
      check("restored limit query", query_cnt_o, 2);

      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      repeat (2) @(negedge clk);
      check("clear query", query_cnt_o, 0);

      set_req(0, 1, 1); set_req(1, 1, 2); set_req(2, 1, 3);
      for (int rnd = 0; rnd < 2; rnd++) begin
         @(negedge clk);
         req_i = 3'b111;
         for (int j = 0; j < 3; j++) begin
            expect_gnt($sformatf("rr%0d.%0d", rnd, j), (j == 0) ? 2 : 3, 3'(1 << j), 8'(2 * j + rnd), 0, 0);
            req_i[j] = 1'b0;
         end
      end

      set_req(0, 2, 3);
      @(negedge clk);
      req_i[0] = 1'b1;
      expect_gnt("pre-clear", 2, 3'b001, 28, 0, 0);
      req_i[0] = 1'b0;
      @(negedge clk);
      req_i[0] = 1'b1;
      @(negedge clk);
      check("check busy", busy_o, 1);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      check("abort gnt", gnt_o, 0);
      check("abort busy", busy_o, 0);
      expect_gnt("regrant", 2, 3'b001, 28, 0, 0);
      req_i[0] = 1'b0;
      repeat (2) @(negedge clk);
      check("regrant query", query_cnt_o, 1);

      req_i[0] = 1'b1;
      expect_gnt("grant-clear", 2, 3'b001, 29, 0, 0);
      clear_i = 1'b1;
      #1;
      check("clear in grant gnt", gnt_o, 0);
      check("clear in grant slot", gnt_slot_o, 0);
      @(negedge clk);
      clear_i = 1'b0;
      expect_gnt("after grant-clear", 2, 3'b001, 28, 0, 0);
      req_i[0] = 1'b0;
      @(negedge clk);

      req_i[0] = 1'b1;
      expect_gnt("pre-reset", 2, 3'b001, 29, 0, 0);
      rst_n = 1'b0;
      #1;
      check("reset in grant gnt", gnt_o, 0);
      check("reset in grant busy", busy_o, 0);
      check("reset in grant slot", gnt_slot_o, 0);
      req_i = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post-reset query", query_cnt_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
